skel_clock_gen: RTL and testbench



---
 rtl/skel_clock_gen.sv | 164 ++++++++++++++++
 tb/tb_skel_clock_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skel_clock_gen.sv
// Multi-channel programmable clock divider with per-channel rise/fall strobes,
// a valid/ready ratio-update port and a common-phase restart.

module skel_clock_gen_ch #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_d,
    input  logic             zero_cnt,
    input  logic             apply,
    input  logic [CNT_W-1:0] apply_div,
    output logic             at_bnd,
    output logic             div_zero,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W:0]   hi_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        div_zero = (div_q == '0);
        at_bnd   = !div_zero && (cnt_q == div_q - CNT_W'(1));
        div_d    = div_q;
        if (zero_cnt || div_zero || at_bnd) cnt_d = '0;
        else                                cnt_d = cnt_q + CNT_W'(1);
        // A ratio change always restarts the period, so no phase is cut short.
        if (apply) begin
            div_d = apply_div;
            cnt_d = '0;
        end
        hi_d   = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
        clk_d  = run_d && (div_d != '0) && ({1'b0, cnt_d} < hi_d);
        rise_d = run_d && (div_d != '0) && (cnt_d == '0);
        fall_d = run_d && (div_d >= CNT_W'(2)) && ({1'b0, cnt_d} == hi_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEF_DIV);
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            clk_q  <= clk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign clk_out  = clk_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
endmodule

module skel_clock_gen #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise_stb,
    output logic [NUM_CH-1:0] fall_stb,
    output logic              err_stb,
    output logic              running
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [CH_W-1:0]   pch_q, pch_d;
    logic [CNT_W-1:0]  pdiv_q, pdiv_d;
    logic              err_q, err_d;
    logic              accept, ch_bad, zero_cnt, force_apply;
    logic [NUM_CH-1:0] at_bnd, div_zero, apply;

    assign cfg_ready   = !pend_q;
    assign accept      = cfg_valid && cfg_ready;
    assign ch_bad      = {1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH);
    assign zero_cnt    = (state_q == IDLE) || !enable || sync_restart;
    assign force_apply = (state_q == IDLE) || sync_restart;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pending update is held until its channel can take it without a glitch.
    always_comb begin
        pend_d = pend_q;
        pch_d  = pch_q;
        pdiv_d = pdiv_q;
        err_d  = accept && ch_bad;
        if (|apply) pend_d = 1'b0;
        if (accept && !ch_bad) begin
            pend_d = 1'b1;
            pch_d  = cfg_ch;
            pdiv_d = cfg_div;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            pch_q   <= '0;
            pdiv_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pch_q   <= pch_d;
            pdiv_q  <= pdiv_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign apply[i] = pend_q && (pch_q == CH_W'(i)) &&
                          (force_apply || at_bnd[i] || div_zero[i]);

        skel_clock_gen_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .run_d     (state_d == RUN),
            .zero_cnt  (zero_cnt),
            .apply     (apply[i]),
            .apply_div (pdiv_q),
            .at_bnd    (at_bnd[i]),
            .div_zero  (div_zero[i]),
            .clk_out   (clk_out[i]),
            .rise_stb  (rise_stb[i]),
            .fall_stb  (fall_stb[i])
        );
    end

    assign err_stb = err_q;
    assign running = (state_q == RUN);
endmodule

// File: tb/tb_skel_clock_gen.sv
// Randomized and directed bench for skel_clock_gen against a period-position model.

module tb_skel_clock_gen;
    localparam int NC = 4;

    logic       clock, reset, enable, sync_restart, cfg_valid;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_ready, err_stb, running;
    logic [3:0] clk_out, rise_stb, fall_stb;
    logic       e_ready, e_err, e_run;
    logic [2:0] e_clk, e_rise, e_fall;
    logic [14:0] obs;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Model: position within the current period and ratio per channel.
    bit m_run, m_pend, m_err;
    int m_pos[NC];
    int m_div[NC];
    int m_pch, m_pdiv;

    skel_clock_gen #(.NUM_CH(4), .CNT_W(8), .DEF_DIV(2)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .sync_restart(sync_restart),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .clk_out(clk_out), .rise_stb(rise_stb), .fall_stb(fall_stb),
        .err_stb(err_stb), .running(running)
    );

    // Three-channel copy so an out-of-range channel index is expressible.
    skel_clock_gen #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(2)) u_err (
        .clock(clock), .reset(reset), .enable(enable), .sync_restart(sync_restart),
        .cfg_valid(cfg_valid), .cfg_ready(e_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .clk_out(e_clk), .rise_stb(e_rise), .fall_stb(e_fall),
        .err_stb(e_err), .running(e_run)
    );

    assign obs = {clk_out, rise_stb, fall_stb, err_stb, running, cfg_ready};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_err = 0; m_pch = 0; m_pdiv = 0;
        for (int i = 0; i < NC; i++) begin
            m_pos[i] = 0;
            m_div[i] = 2;
        end
    endtask

    task automatic model_step();
        bit acc, app;
        int c;
        acc = cfg_valid && !m_pend;
        app = 0;
        c   = m_pch;
        if (m_pend)
            app = !m_run || (m_div[c] == 0) || (sync_restart == 1'b1) ||
                  (m_pos[c] == m_div[c] - 1);
        if (!m_run) begin
            m_run = (enable == 1'b1);
        end else if (enable !== 1'b1) begin
            m_run = 0;
            for (int i = 0; i < NC; i++) m_pos[i] = 0;
        end else if (sync_restart === 1'b1) begin
            for (int i = 0; i < NC; i++) m_pos[i] = 0;
        end else begin
            for (int i = 0; i < NC; i++)
                m_pos[i] = (m_div[i] == 0) ? 0 : (m_pos[i] + 1) % m_div[i];
        end
        if (app) begin
            m_div[c] = m_pdiv;
            m_pos[c] = 0;
            m_pend   = 0;
        end
        m_err = 0;
        if (acc) begin
            if (int'(cfg_ch) >= NC) m_err = 1;
            else begin
                m_pend = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div);
            end
        end
    endtask

    function automatic logic [14:0] m_exp();
        logic [3:0] c, r, f;
        int hi;
        c = '0; r = '0; f = '0;
        for (int i = 0; i < NC; i++) begin
            hi = (m_div[i] + 1) / 2;
            if (m_run && m_div[i] != 0) begin
                c[i] = (m_pos[i] < hi);
                r[i] = (m_pos[i] == 0);
                f[i] = (m_div[i] >= 2) && (m_pos[i] == hi);
            end
        end
        return {c, r, f, m_err, m_run, !m_pend};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 0; enable = 0; sync_restart = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
        model_reset();
        #2;
        chk_cnt++;
        if (obs !== 15'h0001) $display("FAIL reset_async obs=%h exp=%h", obs, 15'h0001);
        else pass_cnt++;
        @(negedge clock);
        reset = 1;
        #1;
        chk_cnt++;
        if (obs !== m_exp() || e_ready !== 1'b1 || e_err !== 1'b0)
            $display("FAIL reset_release obs=%h exp=%h e_ready=%b", obs, m_exp(), e_ready);
        else pass_cnt++;
    endtask

    task automatic test_default_div();
        logic [3:0] e;
        enable = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            e = (k % 2 == 0) ? 4'hF : 4'h0;
            chk_cnt++;
            if ({clk_out, rise_stb, fall_stb} !== {e, e, ~e} || running !== 1'b1)
                $display("FAIL default_div k=%0d got=%h exp=%h", k,
                         {clk_out, rise_stb, fall_stb}, {e, e, ~e});
            else pass_cnt++;
        end
    endtask

    task automatic test_ch1_d5();
        int lo;
        for (int n = 0; n < 4 && m_pos[1] != 1; n++) tick();
        cfg_valid = 1; cfg_ch = 1; cfg_div = 5;
        tick();
        cfg_valid = 0;
        lo = 0;
        for (int n = 0; n < 20; n++) begin
            if (cfg_ready === 1'b1) break;
            chk_cnt++;
            if (obs !== m_exp()) $display("FAIL ch1_wait obs=%h exp=%h", obs, m_exp());
            else pass_cnt++;
            lo++;
            tick();
        end
        chk_cnt++;
        if (lo != 2) $display("FAIL ch1_ready_low cycles=%0d exp=2", lo);
        else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            chk_cnt++;
            if ({clk_out[1], rise_stb[1], fall_stb[1]} !== {k % 5 < 3, k % 5 == 0, k % 5 == 3} ||
                obs !== m_exp())
                $display("FAIL ch1_d5 k=%0d obs=%h exp=%h", k, obs, m_exp());
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic write_wait(input logic [1:0] ch, input logic [7:0] dv, input string nm);
        cfg_valid = 1; cfg_ch = ch; cfg_div = dv;
        tick();
        cfg_valid = 0;
        for (int n = 0; n < 600 && m_pend; n++) begin
            chk_cnt++;
            if (obs !== m_exp()) $display("FAIL %s obs=%h exp=%h", nm, obs, m_exp());
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_special();
        write_wait(2'd2, 8'd1, "wr_ch2_d1");
        write_wait(2'd3, 8'd0, "wr_ch3_d0");
        for (int k = 0; k < 6; k++) begin
            chk_cnt++;
            if ({clk_out[3:2], rise_stb[3:2], fall_stb[3:2]} !== 6'b01_01_00 || obs !== m_exp())
                $display("FAIL special k=%0d obs=%h exp=%h", k, obs, m_exp());
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_err();
        bit ok;
        ok = 0;
        for (int n = 0; n < 600; n++) begin
            if (!m_pend && e_ready === 1'b1) begin ok = 1; break; end
            tick();
        end
        chk_cnt++;
        if (!ok) $display("FAIL err_wait_ready timeout e_ready=%b", e_ready);
        else pass_cnt++;
        cfg_valid = 1; cfg_ch = 3; cfg_div = 9;
        tick();
        cfg_valid = 0;
        chk_cnt++;
        if (e_err !== 1'b1 || e_ready !== 1'b1 || obs !== m_exp())
            $display("FAIL err_pulse e_err=%b e_ready=%b obs=%h exp=%h", e_err, e_ready, obs, m_exp());
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (e_err !== 1'b0 || e_ready !== 1'b1 || obs !== m_exp())
            $display("FAIL err_clear e_err=%b e_ready=%b obs=%h exp=%h", e_err, e_ready, obs, m_exp());
        else pass_cnt++;
        for (int n = 0; n < 600 && m_pend; n++) tick();
        cfg_valid = 1; cfg_ch = 2; cfg_div = 3;
        tick();
        cfg_valid = 0;
        chk_cnt++;
        if (e_err !== 1'b0 || e_ready !== 1'b0)
            $display("FAIL err_valid_ch e_err=%b e_ready=%b exp 0/0", e_err, e_ready);
        else pass_cnt++;
        for (int n = 0; n < 600 && m_pend; n++) tick();
    endtask

    task automatic test_sync_restart();
        write_wait(2'd0, 8'd3, "wr_ch0_d3");
        write_wait(2'd1, 8'd4, "wr_ch1_d4");
        tick();
        tick();
        sync_restart = 1;
        tick();
        sync_restart = 0;
        chk_cnt++;
        if (rise_stb !== 4'hF || clk_out[1:0] !== 2'b11 || obs !== m_exp())
            $display("FAIL sync_restart rise=%b clk=%b obs=%h exp=%h", rise_stb, clk_out, obs, m_exp());
        else pass_cnt++;
        tick();
        cfg_valid = 1; cfg_ch = 1; cfg_div = 6;
        tick();
        cfg_valid = 0;
        sync_restart = 1;
        tick();
        sync_restart = 0;
        chk_cnt++;
        if (cfg_ready !== 1'b1 || rise_stb !== 4'hF || obs !== m_exp())
            $display("FAIL sync_apply ready=%b rise=%b obs=%h exp=%h", cfg_ready, rise_stb, obs, m_exp());
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_cnt++;
            if (obs !== m_exp()) $display("FAIL sync_after k=%0d obs=%h exp=%h", k, obs, m_exp());
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midrun();
        logic [3:0] e;
        cfg_valid = 1; cfg_ch = 0; cfg_div = 7;
        tick();
        cfg_valid = 0;
        chk_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL midrun_pending ready=%b exp=0", cfg_ready);
        else pass_cnt++;
        #2 reset = 0;
        #1;
        model_reset();
        chk_cnt++;
        if (obs !== 15'h0001 || obs !== m_exp())
            $display("FAIL midrun_reset obs=%h exp=%h", obs, 15'h0001);
        else pass_cnt++;
        @(negedge clock);
        reset = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            e = (k % 2 == 0) ? 4'hF : 4'h0;
            chk_cnt++;
            if ({clk_out, rise_stb, fall_stb} !== {e, e, ~e} || obs !== m_exp())
                $display("FAIL midrun_restart k=%0d obs=%h exp=%h", k, obs, m_exp());
            else pass_cnt++;
        end
    endtask

    task automatic test_enable_drop();
        write_wait(2'd3, 8'd0, "wr_ch3_d0b");
        write_wait(2'd1, 8'd5, "wr_ch1_d5b");
        tick();
        tick();
        enable = 0;
        tick();
        chk_cnt++;
        if (running !== 1'b0 || clk_out !== 4'h0 || obs !== m_exp())
            $display("FAIL enable_drop running=%b clk=%b obs=%h exp=%h", running, clk_out, obs, m_exp());
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_cnt++;
            if (obs !== m_exp()) $display("FAIL idle_hold obs=%h exp=%h", obs, m_exp());
            else pass_cnt++;
        end
        enable = 1;
        tick();
        chk_cnt++;
        if (rise_stb !== 4'b0111 || clk_out !== 4'b0111 || running !== 1'b1)
            $display("FAIL reenable rise=%b clk=%b running=%b exp 0111/0111/1",
                     rise_stb, clk_out, running);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int divs[8] = '{0, 1, 2, 3, 4, 5, 7, 255};
        for (int k = 0; k < 600; k++) begin
            enable       = ($urandom_range(0, 19) != 0);
            sync_restart = ($urandom_range(0, 24) == 0);
            cfg_valid    = ($urandom_range(0, 2) == 0);
            cfg_ch       = 2'($urandom_range(0, 3));
            cfg_div      = 8'(divs[$urandom_range(0, 7)]);
            tick();
            chk_cnt++;
            if (obs !== m_exp()) $display("FAIL random k=%0d obs=%h exp=%h", k, obs, m_exp());
            else pass_cnt++;
        end
        enable = 1; sync_restart = 0; cfg_valid = 0;
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_ch1_d5();
        test_special();
        test_err();
        test_sync_restart();
        test_reset_midrun();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end
endmodule
